// File: rtl/instance_id_arbiter_if.sv
// Request/grant bundle between requesters (master) and instance_id_arbiter (slave).
// Carries the per-requester request/release vectors and the registered grant outputs.
interface instance_id_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 32
);
    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  done;
    logic [NUM_REQ-1:0]  gnt;
    logic                gnt_valid;
    logic [ID_WIDTH-1:0] gnt_id;
    logic [15:0]         grant_cnt;
    logic                timeout;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_id, grant_cnt, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_id, grant_cnt, timeout
    );
endinterface

// File: rtl/instance_id_arbiter.sv
// Round-robin single-owner arbiter that reports the owner's instance ID.
// Optional grant watchdog enabled by defining INSTANCE_ID_ARBITER_TIMEOUT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no owner; grant the first request at/after ptr on next edge
// ST_OWNED | owner holds the resource until DONE, REQ drop or watchdog
module instance_id_arbiter #(
    parameter int                  NUM_REQ        = 4,
    parameter int                  ID_WIDTH       = 32,
    parameter logic [ID_WIDTH-1:0] ID_BASE        = ID_WIDTH'(32'hDEADBEEF),
    parameter int                  TIMEOUT_CYCLES = 255
) (
    input logic                    clk,
    input logic                    resetn,
    instance_id_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]          state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    owner;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                gnt_valid_q;
    logic [ID_WIDTH-1:0] gnt_id_q;
    logic [15:0]         grant_cnt_q;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic                owner_release;
    logic                force_rel;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Scan from the highest offset down so the nearest request to ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[wrap_add(ptr, i)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(ptr, i);
            end
        end
    end

    assign owner_release = bus.done[owner] | ~bus.req[owner];

`ifdef INSTANCE_ID_ARBITER_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        timeout_q;

    // A genuine release on the limit cycle wins over the watchdog.
    assign force_rel = (state == ST_OWNED) && !owner_release &&
                       (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if (state == ST_IDLE) wd_cnt <= '0;
            else                  wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign force_rel   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            owner       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            grant_cnt_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state       <= ST_OWNED;
                        owner       <= pick_idx;
                        gnt_q       <= NUM_REQ'(1) << pick_idx;
                        gnt_valid_q <= 1'b1;
                        gnt_id_q    <= ID_BASE + ID_WIDTH'(pick_idx);
                        grant_cnt_q <= grant_cnt_q + 16'd1;
                    end
                end
                ST_OWNED: begin
                    if (owner_release || force_rel) begin
                        state       <= ST_IDLE;
                        ptr         <= wrap_add(owner, 1);
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        gnt_id_q    <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.grant_cnt = grant_cnt_q;
endmodule

// File: doc/instance_id_arbiter.md
INSTANCE_ID_ARBITER -- requirements
Module: instance_id_arbiter

Interface
- REQ-001: Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing the resource (legal range 2..16).
- REQ-002: Parameter ID_WIDTH, default 32, SHALL set the width of the reported instance ID.
- REQ-003: Parameter ID_BASE, default 32'hDEADBEEF, SHALL set the instance ID of requester 0; requester k has ID (ID_BASE + k) mod 2^ID_WIDTH.
- REQ-004: Parameter TIMEOUT_CYCLES, default 255, SHALL set the watchdog limit (used only under REQ-024).
- REQ-005: CLK  input  1  sole clock; all state updates on rising edge.
- REQ-006: RESETN  input  1  synchronous, active-low reset.
- REQ-007: REQ  input  NUM_REQ  per-requester request, level, held until granted and done.
- REQ-008: DONE  input  NUM_REQ  per-requester release pulse; only the bit of the current owner is honoured.
- REQ-009: GNT  output  NUM_REQ  one-hot registered grant, all-zero when no owner.
- REQ-010: GNT_VALID  output  1  high while a grant is held.
- REQ-011: GNT_ID  output  ID_WIDTH  instance ID of the current owner; 0 when GNT_VALID is low.
- REQ-012: GRANT_CNT  output  16  count of grants issued since reset, wraps 16'hFFFF -> 0.
- REQ-013: TIMEOUT  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
- REQ-014: The FSM SHALL have two states, IDLE and OWNED; all outputs SHALL be registered.
- REQ-015: In IDLE with REQ == 0, state, GNT, GNT_VALID, GNT_ID SHALL stay at idle values.
- REQ-016: In IDLE with REQ != 0, the next cycle SHALL enter OWNED with GNT set to the first asserted REQ bit at or after the round-robin pointer, searching upward and wrapping from NUM_REQ-1 to 0 (grant latency 1 cycle).
- REQ-017: On entry to OWNED, GNT_VALID SHALL be 1, GNT_ID SHALL be ID_BASE + index (modulo 2^ID_WIDTH), and GRANT_CNT SHALL increment by 1.
- REQ-018: In OWNED, GNT SHALL remain stable regardless of other REQ bits.
- REQ-019: In OWNED, if DONE[owner] is 1 or REQ[owner] is 0 (abort), the next cycle SHALL return to IDLE with GNT = 0, GNT_VALID = 0, GNT_ID = 0; simultaneous DONE and REQ drop count as one release.
- REQ-020: On any release the pointer SHALL become (owner + 1) mod NUM_REQ; a new grant therefore appears no earlier than 2 cycles after the DONE cycle.
- REQ-021: DONE bits of non-owners, and all DONE bits in IDLE, SHALL be ignored.

Reset
- REQ-022: With RESETN low at a rising edge: state IDLE, pointer 0, GNT 0, GNT_VALID 0, GNT_ID 0, GRANT_CNT 0, TIMEOUT 0, watchdog counter 0.
- REQ-023: Reset asserted while OWNED SHALL drop the grant on that edge, with no TIMEOUT pulse and no GRANT_CNT change beyond clearing.

Configuration
- REQ-024: With macro INSTANCE_ID_ARBITER_TIMEOUT_EN defined, a watchdog counter SHALL clear on entry to OWNED, increment each OWNED cycle, and on reaching TIMEOUT_CYCLES without release force a release per REQ-019/REQ-020 with TIMEOUT pulsed high for exactly the cycle GNT drops; a release on the same cycle the limit is reached SHALL be a normal release with TIMEOUT 0.
- REQ-025: Without the macro, no watchdog SHALL exist, TIMEOUT SHALL be constant 0, and grants SHALL be held indefinitely.

Verification
- REQ-026: Reset, then REQ=4'b0100 -> next cycle GNT=4'b0100, GNT_ID=32'hDEADBEF1, GNT_VALID=1, GRANT_CNT=1.
- REQ-027: REQ=4'b1111 held, owner pulses DONE each grant -> grant order 0,1,2,3,0 with one idle cycle between grants.
- REQ-028: ID_BASE=32'hFFFFFFFF, REQ=4'b0010 -> GNT_ID=32'h00000000 (wrap).
- REQ-029: Owner 1 granted, DONE=4'b0001 pulsed -> grant held; then REQ[1] dropped -> GNT=0 next cycle, pointer=2.
- REQ-030: Macro defined, TIMEOUT_CYCLES=8, owner never releases -> GNT drops and TIMEOUT=1 for one cycle after 8 OWNED cycles; macro undefined -> grant held 1000 cycles, TIMEOUT=0.
- REQ-031: RESETN driven low mid-grant with GRANT_CNT=5 -> next edge all outputs 0, then REQ=4'b0001 grants requester 0.
